// File: rtl/led_dimmer_pkg.sv
// Shared types and constants for the PWM LED dimmer datapath.
package led_dimmer_pkg;

  localparam int unsigned DUTY_W   = 4;
  localparam int unsigned DUTY_MAX = (1 << DUTY_W) - 1;

  typedef logic [DUTY_W-1:0] duty_t;

  typedef enum logic [1:0] {
    StManual,
    StBreatheUp,
    StBreatheDown
  } state_e;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, stability debounce and registered rising-edge press pulse
// for one raw mechanical input.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_press
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_level;
  logic            r_level_prev;
  logic            r_press;
  logic [CntW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Level is accepted only after DEBOUNCE_CYCLES consecutive mismatching samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (r_sync2 == r_level) begin
      r_cnt <= '0;
    end else if (r_cnt == CntLast) begin
      r_cnt   <= '0;
      r_level <= r_sync2;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level_prev <= 1'b0;
      r_press      <= 1'b0;
    end else begin
      r_level_prev <= r_level;
      r_press      <= r_level & ~r_level_prev;
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;

endmodule

// File: rtl/led_brightness_ctrl.sv
// Brightness controller: manual up/down stepping or a continuous 0..max..0 breathe ramp,
// producing the registered duty word for the PWM stage.
module led_brightness_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned STEP_CYCLES     = 3125000,
  parameter int unsigned DUTY_W          = led_dimmer_pkg::DUTY_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              mode_breathe,
  output logic [DUTY_W-1:0] duty_cycle,
  output logic              at_max,
  output logic              at_min
);

  import led_dimmer_pkg::*;

  localparam logic [DUTY_W-1:0] DutyMax  = {DUTY_W{1'b1}};
  localparam int unsigned       StepW    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [StepW-1:0]  StepLast = StepW'(STEP_CYCLES - 1);

  logic              w_up_press;
  logic              w_down_press;
  logic              w_mode;
  logic              w_up_level_unused;
  logic              w_down_level_unused;
  logic              w_mode_press_unused;
  logic              w_tick;
  state_e            r_state;
  state_e            w_state_next;
  logic [DUTY_W-1:0] r_duty;
  logic [DUTY_W-1:0] w_duty_next;
  logic [StepW-1:0]  r_step_cnt;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_db_up (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_raw   (btn_up),
    .o_level (w_up_level_unused),
    .o_press (w_up_press)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_db_down (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_raw   (btn_down),
    .o_level (w_down_level_unused),
    .o_press (w_down_press)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_db_mode (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_raw   (mode_breathe),
    .o_level (w_mode),
    .o_press (w_mode_press_unused)
  );

  assign w_tick = (r_state != StManual) && (r_step_cnt == StepLast);

  // Prescaler idles at zero in manual mode, so breathe entry always starts a fresh step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step_cnt <= '0;
    end else if (r_state == StManual || w_tick) begin
      r_step_cnt <= '0;
    end else begin
      r_step_cnt <= r_step_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_duty_next  = r_duty;
    unique case (r_state)
      StManual: begin
        if (w_mode) begin
          w_state_next = StBreatheUp;
        end else if (w_up_press && !w_down_press) begin
          if (r_duty != DutyMax) w_duty_next = r_duty + 1'b1;
        end else if (w_down_press && !w_up_press) begin
          if (r_duty != '0) w_duty_next = r_duty - 1'b1;
        end
      end
      StBreatheUp: begin
        if (!w_mode) begin
          w_state_next = StManual;
        end else if (w_tick) begin
          if (r_duty == DutyMax) begin
            w_duty_next  = r_duty - 1'b1;
            w_state_next = StBreatheDown;
          end else begin
            w_duty_next = r_duty + 1'b1;
            if (r_duty == DutyMax - 1'b1) w_state_next = StBreatheDown;
          end
        end
      end
      StBreatheDown: begin
        if (!w_mode) begin
          w_state_next = StManual;
        end else if (w_tick) begin
          if (r_duty == '0) begin
            w_duty_next  = r_duty + 1'b1;
            w_state_next = StBreatheUp;
          end else begin
            w_duty_next = r_duty - 1'b1;
            if (r_duty == DUTY_W'(1)) w_state_next = StBreatheUp;
          end
        end
      end
      default: w_state_next = StManual;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StManual;
      r_duty  <= '0;
    end else begin
      r_state <= w_state_next;
      r_duty  <= w_duty_next;
    end
  end

  assign duty_cycle = r_duty;
  assign at_max     = (r_duty == DutyMax);
  assign at_min     = (r_duty == '0);

endmodule
